fp_hazard_scoreboard: RTL

//  Parametrised FP hazard/forwarding unit for the pipelined CPU ID stage. Tracks pending FPR writes
//  in a PIPE_DEPTH-stage add/sub/mul pipe and a multi-cycle div/sqrt sequencer, and drives stall and

---
 rtl/fp_ctrl_pkg.sv | 30 +++
 rtl/fp_hazard_scoreboard_if.sv | 37 +++
 rtl/fp_div_seq.sv | 67 ++++++
 rtl/fp_hazard_scoreboard.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fp_ctrl_pkg.sv
// FP control encodings shared by the hazard scoreboard, its interface and the div/sqrt sequencer.
package fp_ctrl_pkg;

    localparam logic [2:0] FOP_NONE = 3'd0;
    localparam logic [2:0] FOP_ADD  = 3'd1;
    localparam logic [2:0] FOP_SUB  = 3'd2;
    localparam logic [2:0] FOP_MUL  = 3'd3;
    localparam logic [2:0] FOP_DIV  = 3'd4;
    localparam logic [2:0] FOP_SQRT = 3'd5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_DIV = 2'b10;
    localparam logic [1:0] FWD_LW  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic is_pipe_op(input logic [2:0] fop);
        return (fop == FOP_ADD) || (fop == FOP_SUB) || (fop == FOP_MUL);
    endfunction

    function automatic logic is_div_op(input logic [2:0] fop);
        return (fop == FOP_DIV) || (fop == FOP_SQRT);
    endfunction

endpackage

// File: rtl/fp_hazard_scoreboard_if.sv
// ID-stage request / hazard-response bundle between the decode stage and the FP scoreboard.
interface fp_hazard_scoreboard_if #(
    parameter int RN_W = 5
);
    logic [2:0]      id_fop;
    logic            id_wf;
    logic [RN_W-1:0] id_fd;
    logic [RN_W-1:0] id_fs;
    logic            id_use_fs;
    logic [RN_W-1:0] id_ft;
    logic            id_use_ft;
    logic            ewfpr;
    logic [RN_W-1:0] ern;
    logic            mwfpr;
    logic [RN_W-1:0] mrn;
    logic            ext_stall;

    logic            stall;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            div_busy;
    logic            wb_valid;
    logic [RN_W-1:0] wb_rn;
    logic            wb_src;

    modport master (
        output id_fop, id_wf, id_fd, id_fs, id_use_fs, id_ft, id_use_ft,
               ewfpr, ern, mwfpr, mrn, ext_stall,
        input  stall, fwd_a, fwd_b, div_busy, wb_valid, wb_rn, wb_src
    );

    modport slave (
        input  id_fop, id_wf, id_fd, id_fs, id_use_fs, id_ft, id_use_ft,
               ewfpr, ern, mwfpr, mrn, ext_stall,
        output stall, fwd_a, fwd_b, div_busy, wb_valid, wb_rn, wb_src
    );
endinterface

// File: rtl/fp_div_seq.sv
// Multi-cycle div/sqrt sequencer: tracks latency, destination register and the single done cycle.
module fp_div_seq
    import fp_ctrl_pkg::*;
#(
    parameter int RN_W       = 5,
    parameter int DIV_CYCLES = 12,
    localparam int CNT_W     = $clog2(DIV_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RN_W-1:0]  start_rn,
    output logic             busy,
    output logic             done,
    output logic [RN_W-1:0]  div_rn,
    output logic [CNT_W-1:0] cnt
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RN_W-1:0]  rn_q, rn_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rn_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rn_q    <= rn_d;
        end
    end

    // DONE accepts a new start so back-to-back divides lose no cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rn_d    = rn_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    rn_d    = start_rn;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == BUSY);
    assign done   = (state_q == DONE);
    assign div_rn = rn_q;
    assign cnt    = cnt_q;

endmodule

// File: rtl/fp_hazard_scoreboard.sv
// FP hazard/forwarding unit for ID: pending-write shift register for the pipelined FPU plus
// div/sqrt sequencer tracking, producing stall, operand forward selects and writeback info.
module fp_hazard_scoreboard
    import fp_ctrl_pkg::*;
#(
    parameter int RN_W       = 5,
    parameter int PIPE_DEPTH = 3,
    parameter int DIV_CYCLES = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_hazard_scoreboard_if.slave bus
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic             stg_v  [PIPE_DEPTH];
    logic [RN_W-1:0]  stg_rn [PIPE_DEPTH];

    logic             div_busy, div_done;
    logic [RN_W-1:0]  div_rn;
    logic [CNT_W-1:0] div_cnt;

    logic             want_issue, issue, issue_pipe, issue_div;
    logic             struct_stall, div_stall, waw_stall, stall;
    logic [RN_W-1:0]  src     [2];
    logic             src_use [2];
    logic             raw     [2];
    logic [1:0]       fwd     [2];

    fp_div_seq #(
        .RN_W       (RN_W),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (issue_div),
        .start_rn (bus.id_fd),
        .busy     (div_busy),
        .done     (div_done),
        .div_rn   (div_rn),
        .cnt      (div_cnt)
    );

    // The FPU never freezes: stages shift every cycle and a stalled ID slot enters as a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_v[0]  <= 1'b0;
            stg_rn[0] <= '0;
        end else begin
            stg_v[0]  <= issue_pipe;
            stg_rn[0] <= bus.id_fd;
        end
    end

    for (genvar k = 1; k < PIPE_DEPTH; k++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stg_v[k]  <= 1'b0;
                stg_rn[k] <= '0;
            end else begin
                stg_v[k]  <= stg_v[k-1];
                stg_rn[k] <= stg_rn[k-1];
            end
        end
    end

    assign src[0]     = bus.id_fs;
    assign src[1]     = bus.id_ft;
    assign src_use[0] = bus.id_use_fs;
    assign src_use[1] = bus.id_use_ft;

    // Only the last stage forwards; younger stages can only be waited on.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            raw[i] = 1'b0;
            fwd[i] = FWD_REG;
            if (src_use[i]) begin
                for (int unsigned k = 0; k < PIPE_DEPTH - 1; k++) begin
                    if (stg_v[k] && (stg_rn[k] == src[i])) raw[i] = 1'b1;
                end
                if (div_busy && (div_rn == src[i]))    raw[i] = 1'b1;
                if (bus.ewfpr && (bus.ern == src[i]))  raw[i] = 1'b1;

                if (stg_v[PIPE_DEPTH-1] && (stg_rn[PIPE_DEPTH-1] == src[i])) fwd[i] = FWD_EXE;
                else if (div_done && (div_rn == src[i]))                     fwd[i] = FWD_DIV;
                else if (bus.mwfpr && (bus.mrn == src[i]))                   fwd[i] = FWD_LW;
            end
        end
    end

    // Stall terms use the would-be issue, not issue itself, to keep stall free of a loop.
    assign want_issue   = bus.id_wf && (bus.id_fop != FOP_NONE);
    assign struct_stall = want_issue && is_pipe_op(bus.id_fop) && div_busy
                          && (div_cnt == CNT_W'(PIPE_DEPTH));
    assign div_stall    = want_issue && is_div_op(bus.id_fop) && div_busy;
    assign waw_stall    = want_issue && div_busy && (bus.id_fd == div_rn);
    assign stall        = bus.ext_stall || raw[0] || raw[1]
                          || struct_stall || div_stall || waw_stall;

    assign issue      = !stall && want_issue;
    assign issue_pipe = issue && is_pipe_op(bus.id_fop);
    assign issue_div  = issue && is_div_op(bus.id_fop);

    always_comb begin
        bus.wb_valid = 1'b0;
        bus.wb_rn    = '0;
        bus.wb_src   = 1'b0;
        if (stg_v[PIPE_DEPTH-1]) begin
            bus.wb_valid = 1'b1;
            bus.wb_rn    = stg_rn[PIPE_DEPTH-1];
        end else if (div_done) begin
            bus.wb_valid = 1'b1;
            bus.wb_rn    = div_rn;
            bus.wb_src   = 1'b1;
        end
    end

    assign bus.stall    = stall;
    assign bus.fwd_a    = fwd[0];
    assign bus.fwd_b    = fwd[1];
    assign bus.div_busy = div_busy;

endmodule
